// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles big-endian words from a framed stream and writes i_mem.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int unsigned          ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
   parameter int unsigned          MAX_WORDS = 64
) (
   input  logic              clock,
   input  logic              Reset,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [15:0]       words_loaded
);

   typedef enum logic [2:0] {
      S_LEN,
      S_DATA,
      S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM,
`endif
      S_DONE,
      S_ERR
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] len_q;
   logic [31:0] word_q;
   logic [1:0]  byte_cnt;
   logic [31:0] len_next;
   logic [31:0] count_next;
   logic        accept;
   logic        shifting;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  csum_q;
`endif

   assign accept     = in_valid && in_ready;
   assign shifting   = accept && (state_q == S_LEN || state_q == S_DATA);
   assign len_next   = {len_q[23:0], in_data};
   assign count_next = 32'(words_loaded) + 32'd1;

   assign mem_addr  = BASE_ADDR + ADDR_W'({words_loaded, 2'b00});
   assign mem_wdata = word_q;

   always_ff @(posedge clock) begin
      if (Reset) begin
         state_q      <= S_LEN;
         len_q        <= '0;
         word_q       <= '0;
         byte_cnt     <= '0;
         words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q       <= '0;
`endif
      end else begin
         state_q <= state_d;
         if (accept && state_q == S_LEN)
            len_q <= len_next;
         if (accept && state_q == S_DATA)
            word_q <= {word_q[23:0], in_data};
         // 2-bit counter wraps 3->0 so the next word/length starts aligned
         if (shifting)
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (shifting)
            csum_q <= csum_q ^ in_data;
`endif
         if (state_q == S_WRITE)
            words_loaded <= words_loaded + 16'd1;
      end
   end

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      mem_we   = 1'b0;
      done     = 1'b0;
      error    = 1'b0;
      cpu_hold = 1'b1;
      unique case (state_q)
         S_LEN: begin
            in_ready = 1'b1;
            if (accept && byte_cnt == 2'd3) begin
               if (len_next > 32'(MAX_WORDS))
                  state_d = S_ERR;
               else if (len_next == 32'd0)
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_d = S_CSUM;
`else
                  state_d = S_DONE;
`endif
               else
                  state_d = S_DATA;
            end
         end
         S_DATA: begin
            in_ready = 1'b1;
            if (accept && byte_cnt == 2'd3)
               state_d = S_WRITE;
         end
         S_WRITE: begin
            mem_we = 1'b1;
            if (count_next < len_q)
               state_d = S_DATA;
            else
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = S_CSUM;
`else
               state_d = S_DONE;
`endif
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            in_ready = 1'b1;
            if (accept)
               state_d = (in_data == csum_q) ? S_DONE : S_ERR;
         end
`endif
         S_DONE: begin
            done     = 1'b1;
            cpu_hold = 1'b0;
         end
         S_ERR: begin
            error = 1'b1;
         end
         default: state_d = S_ERR;
      endcase
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader: the write side of the instruction memory that the core's fetch path reads. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Each word is written to instruction memory at consecutive byte addresses, and the core is held in reset until the image is complete. It sits between a host link (UART/JTAG bridge) and the i_mem write port. The core's `Reset` is driven from `cpu_hold`.

## Interface
- `ADDR_W`, 32: width of `mem_addr`.
- `BASE_ADDR`, 0: byte address of the first loaded word.
- `MAX_WORDS`, 64: capacity of instruction memory in words.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `mem_we`  out  1  instruction-memory write strobe.
- `mem_addr`  out  ADDR_W  byte address of the write.
- `mem_wdata`  out  32  word to write.
- `cpu_hold`  out  1  core held in reset while high.
- `done`  out  1  image loaded successfully (sticky).
- `error`  out  1  framing/capacity/checksum failure (sticky).
- `words_loaded`  out  16  count of words written.

## Operation
- Frame format:
  - 4 length bytes giving N, big-endian.
  - N×4 data bytes, each word big-endian (first byte is bits 31:24).
  - With `IMEM_LOADER_CHECKSUM_EN`, one trailing checksum byte.
- A byte is accepted on any edge where `in_valid && in_ready`.
- `in_ready` is combinational from state: 1 in LEN, DATA and CSUM; 0 in WRITE, DONE and ERR.
- States and transitions:
  - LEN: shift 4 bytes into the N register. After the 4th byte:
    - N > MAX_WORDS → ERR.
    - N == 0 → CSUM (if enabled), else DONE.
    - Otherwise → DATA.
  - DATA: shift bytes into the word register; the byte counter wraps 3→0. After the 4th byte → WRITE.
  - WRITE: single cycle. `mem_we`=1, `mem_addr`=BASE_ADDR+4·`words_loaded`, `mem_wdata`=assembled word. `words_loaded` increments at the end of the cycle. Next state: DATA if words remain; otherwise CSUM (if enabled) or DONE.
  - CSUM: accept one byte. Equal to the running checksum → DONE; otherwise → ERR.
  - DONE: `done`=1, `cpu_hold`=0. Terminal until `Reset`.
  - ERR: `error`=1, `cpu_hold` stays 1. Terminal until `Reset`; further bytes are not accepted.
- `mem_addr` arithmetic is modulo 2^ADDR_W; `words_loaded` is 16-bit unsigned.
- Reset values: state LEN, `in_ready`=1, `mem_we`=0, `mem_addr`=BASE_ADDR, `mem_wdata`=0, `cpu_hold`=1, `done`=0, `error`=0, `words_loaded`=0. The length, word, byte-counter and checksum registers are cleared.
- Reset during any state, including WRITE, aborts the load. `mem_we` is 0 from the next edge and the loader restarts at LEN.
- Bytes are never dropped: with `in_valid`=1 and `in_ready`=0 the byte is held by the source.

## Timing
- Each byte is consumed in 1 cycle when `in_valid` is high.
- A word write occurs in the cycle after its 4th byte is accepted. Minimum throughput is 5 cycles per word.
- `mem_we` is high for exactly 1 cycle per word. `mem_addr` and `mem_wdata` are stable during that cycle.
- DONE is entered on the edge after the last WRITE, or after the CSUM byte. `done` rises and `cpu_hold` falls in the same cycle.
- ERR is entered on the edge that accepts the offending byte.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - The running checksum is an 8-bit XOR of every accepted length and data byte.
  - The CSUM state exists; one extra byte is expected and compared.
  - A mismatch → ERR.
- Undefined:
  - No checksum logic and no CSUM state.
  - The last WRITE, or N==0, goes directly to DONE.

## Test plan
- Stream 00 00 00 02, 20 08 00 05, 8C 09 00 04 with continuous valid → writes 0x20080005 @0x0 and 0x8C090004 @0x4. `mem_we` is high exactly 2 cycles; `words_loaded`=2; `done`=1, `cpu_hold`=0 one cycle after the second write.
- Same stream with `in_valid` toggled every other cycle → identical writes. `in_ready`=0 during each WRITE cycle; no byte is lost.
- Length 00 00 00 41 with MAX_WORDS=64 → `error`=1 after the 4th byte. `mem_we` never asserts; `in_ready`=0 thereafter.
- Length 00 00 00 00 → `done`=1 with no writes (checksum off). With checksum on, `done`=1 only after byte 00 is sent.
- Checksum on: stream 00 00 00 01, DE AD BE EF, then checksum 0x23 → DONE. Same stream with checksum 0x24 → ERR, `cpu_hold` stays 1.
- Assert `Reset` in the WRITE cycle of word 1 of 2 → next cycle `mem_we`=0, `words_loaded`=0, `cpu_hold`=1. A full reload then writes from BASE_ADDR.
